vram_arbiter: RTL and testbench
===============================

# vram_arbiter

Arbitrates the single-port, synchronous-read board/video RAM between the pixel renderer and the game-logic engine. It takes `vsync` and `active_area` from the raster timing generator and tracks the frame phase. It issues `frame_tick` once per frame and grants game logic an exclusive vertical-blanking lock for frame-coherent board updates. The renderer always has absolute priority, so its read latency is fixed and pixels never stall.

## Interface
Parameters:
- `AW`, 9: memory address width.
- `DW`, 4: memory data width (cell colour/code).

Ports:
- `clk`  in  1: pixel clock (same clock as the timing generator).
- `rst`  in  1: synchronous, active-high reset.
- `vsync`  in  1: active-high vertical sync from the timing generator.
- `active_area`  in  1: visible-region flag from the timing generator.
- `ren_req`  in  1: renderer read request, one per cycle.
- `ren_addr`  in  AW: renderer read address.
- `ren_rdata`  out  DW: renderer read data.
- `ren_valid`  out  1: `ren_rdata` valid.
- `gl_req`  in  1: game-logic access request; held until granted.
- `gl_we`  in  1: 1 = write, 0 = read.
- `gl_addr`  in  AW: game-logic address.
- `gl_wdata`  in  DW: game-logic write data.
- `gl_gnt`  out  1: access accepted this cycle (combinational).
- `gl_rdata`  out  DW: game-logic read data.
- `gl_rvalid`  out  1: `gl_rdata` valid.
- `gl_lock_req`  in  1: request an exclusive vblank window.
- `gl_lock_ack`  out  1: exclusive window held.
- `mem_en`, `mem_we`  out  1: RAM enable and write strobe.
- `mem_addr`  out  AW: RAM address.
- `mem_wdata`  out  DW: RAM write data.
- `mem_rdata`  in  DW: RAM read data, one cycle after `mem_en`.
- `frame_tick`  out  1: one-cycle pulse per frame.
- `frame_count`  out  8: frame counter.

## Operation
Edge detection:
- `vsync` and `active_area` are registered once inside the block.
- Rising edges are detected against the registered copies.

Frame-phase FSM (`ACTIVE`, `VBLANK`):
- Reset state is `VBLANK`.
- `ACTIVE` -> `VBLANK` on a `vsync` rising edge.
- `VBLANK` -> `ACTIVE` on an `active_area` rising edge.
- On entry to `VBLANK`: `frame_tick` = 1 for exactly one cycle, and `frame_count` increments, wrapping 255 -> 0.

Arbitration, evaluated every cycle:
- If `ren_req` = 1, the renderer owns the RAM: `mem_en` = 1, `mem_we` = 0, `mem_addr` = `ren_addr`, and `gl_gnt` = 0.
- Otherwise, if `gl_req` = 1, then `gl_gnt` = 1 and the RAM is driven with `gl_addr`, `gl_we`, `gl_wdata`, `mem_en` = 1.
- Otherwise `mem_en` = 0.
- Game-logic access is permitted in both FSM states; the lock only adds a coherency guarantee.

Read return:
- `ren_valid` is `ren_req` delayed by one cycle, and `ren_rdata` = `mem_rdata`.
- `gl_rvalid` is (`gl_gnt` and not `gl_we`) delayed by one cycle, and `gl_rdata` = `mem_rdata`.
- The two valid signals are never high in the same cycle.

Lock:
- `gl_lock_ack` is registered.
- It rises the cycle after the FSM is in `VBLANK` with `gl_lock_req` = 1.
- It falls the cycle after `gl_lock_req` deasserts or the FSM leaves `VBLANK`, whichever comes first.
- A request made during `ACTIVE` waits for the next `VBLANK`.
- The lock does not block the renderer.

## Timing
Reset values:
- `gl_lock_ack`, `frame_tick`, `ren_valid`, `gl_rvalid` = 0.
- `frame_count` = 0.
- Internal sync registers = 0.
- Combinational outputs follow their inputs during reset, except that `mem_en` and `gl_gnt` are forced to 0.

Latencies:
- Renderer read: 1 cycle, fixed.
- Game-logic grant: 0 cycles when the renderer is idle.
- `frame_tick`: 1 cycle after the `vsync` rising edge is registered, i.e. 2 clocks after the raw edge.

Boundary conditions:
- A `vsync` rise and an `active_area` rise in the same cycle: the `vsync` transition takes precedence.
- Reset asserted mid-lock drops `gl_lock_ack` on the next edge.
- Reset asserted mid-read drops the pending valid.

## Configuration
Macro `VRAM_ARB_STATS_EN` adds a port `gl_stall_count` (out, 16 bits).
- Defined: the counter increments on every cycle with `gl_req` and not `gl_gnt`, saturates at 0xFFFF, and clears on `frame_tick` and on reset.
- Undefined: the port still exists and is tied to 0, with no counter logic.

## Structure
- Package `disp_pkg` holds the `AW`/`DW` default localparams and the `frame_phase_t` enum (`ACTIVE`, `VBLANK`).
- Sub-module `edge_det` is a registered rising-edge detector, instantiated twice (`vsync`, `active_area`).

## Test plan
- Reset, then idle inputs -> all registered outputs 0, FSM in `VBLANK`, `mem_en` = 0.
- `ren_req` every cycle with `ren_addr` = 0..7 against a RAM model preloaded with data = addr -> `ren_valid` 1 cycle later with data 0..7 in order; a simultaneous `gl_req` sees `gl_gnt` = 0 throughout.
- Renderer idle; game-logic write of addr 5, data 0xA, then read of addr 5 -> `gl_gnt` = 1 on each; `gl_rvalid` 1 cycle after the read with `gl_rdata` = 0xA.
- Drive 3 `vsync` pulses -> exactly 3 `frame_tick` pulses, each 2 clocks after the raw rise; `frame_count` = 3. Preload 255 -> wraps to 0.
- `gl_lock_req` asserted during `ACTIVE` -> `gl_lock_ack` stays 0 until the cycle after entry to `VBLANK`, then falls the cycle after the `active_area` rise.
- With `VRAM_ARB_STATS_EN`: 10 cycles of `gl_req` colliding with `ren_req` -> `gl_stall_count` = 10; it clears on the next `frame_tick`.

Source files
------------

// File: rtl/disp_pkg.sv
// ============================================================================
//  Module      : disp_pkg
//  Description : Shared constants and the frame-phase type for the display
//                memory arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package disp_pkg;

    // Default memory geometry: 9-bit cell address, 4-bit cell colour/code.
    localparam int c_aw_def  = 9;
    localparam int c_dw_def  = 4;

    // Width of the frame counter and of the optional stall counter.
    localparam int c_fc_w    = 8;
    localparam int c_stall_w = 16;

    // Frame phase as seen by the arbiter.
    typedef enum logic [0:0] {
        ACTIVE = 1'b0,
        VBLANK = 1'b1
    } frame_phase_t;

endpackage

`default_nettype wire

// File: rtl/edge_det.sv
// ============================================================================
//  Module      : edge_det
//  Description : Registered rising-edge detector. The input is captured once,
//                and a rise is reported when the captured copy is high while
//                its one-cycle-older copy is still low.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module edge_det (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic r_q;
    logic r_q_d;

    // Capture the input and keep one older copy for comparison.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q   <= 1'b0;
            r_q_d <= 1'b0;
        end else begin
            r_q   <= din;
            r_q_d <= r_q;
        end
    end

    assign rise = r_q & ~r_q_d;

endmodule

`default_nettype wire

// File: rtl/vram_arbiter.sv
// ============================================================================
//  Module      : vram_arbiter
//  Description : Shares the single-port synchronous-read video RAM between the
//                pixel renderer (absolute priority, fixed 1-cycle latency) and
//                the game-logic engine. Tracks the frame phase from vsync /
//                active_area, issues frame_tick / frame_count and provides a
//                vertical-blanking lock for frame-coherent board updates.
//                Optional macro VRAM_ARB_STATS_EN enables the game-logic stall
//                counter on gl_stall_count (tied to 0 otherwise).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vram_arbiter
    import disp_pkg::*;
#(
    parameter int AW = c_aw_def,
    parameter int DW = c_dw_def
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 vsync,
    input  logic                 active_area,
    input  logic                 ren_req,
    input  logic [AW-1:0]        ren_addr,
    output logic [DW-1:0]        ren_rdata,
    output logic                 ren_valid,
    input  logic                 gl_req,
    input  logic                 gl_we,
    input  logic [AW-1:0]        gl_addr,
    input  logic [DW-1:0]        gl_wdata,
    output logic                 gl_gnt,
    output logic [DW-1:0]        gl_rdata,
    output logic                 gl_rvalid,
    input  logic                 gl_lock_req,
    output logic                 gl_lock_ack,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [AW-1:0]        mem_addr,
    output logic [DW-1:0]        mem_wdata,
    input  logic [DW-1:0]        mem_rdata,
    output logic                 frame_tick,
    output logic [c_fc_w-1:0]    frame_count,
    output logic [c_stall_w-1:0] gl_stall_count
);

    logic              w_vs_rise;
    logic              w_aa_rise;
    frame_phase_t      r_state;
    frame_phase_t      w_state_nxt;
    logic              w_enter_vblank;
    logic              r_frame_tick;
    logic [c_fc_w-1:0] r_frame_count;
    logic              r_lock_ack;
    logic              r_ren_valid;
    logic              r_gl_rvalid;
    logic              w_gl_sel;

    edge_det u_vsync_edge (
        .clk  (clk),
        .rst  (rst),
        .din  (vsync),
        .rise (w_vs_rise)
    );

    edge_det u_active_edge (
        .clk  (clk),
        .rst  (rst),
        .din  (active_area),
        .rise (w_aa_rise)
    );

    // Frame-phase state register; blanking is the safe power-up phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= VBLANK;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next phase: a vsync rise always wins over a simultaneous active rise.
    always_comb begin
        w_state_nxt    = r_state;
        w_enter_vblank = 1'b0;
        case (r_state)
            ACTIVE: begin
                if (w_vs_rise) begin
                    w_state_nxt    = VBLANK;
                    w_enter_vblank = 1'b1;
                end
            end
            VBLANK: begin
                if (!w_vs_rise && w_aa_rise) begin
                    w_state_nxt = ACTIVE;
                end
            end
            default: begin
                w_state_nxt = VBLANK;
            end
        endcase
    end

    // One tick and one count step on each entry into blanking.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_tick  <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_frame_tick <= w_enter_vblank;
            if (w_enter_vblank) begin
                r_frame_count <= r_frame_count + 1'b1;
            end
        end
    end

    // Lock is held while in blanking and requested; drops one cycle after either goes away.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lock_ack <= 1'b0;
        end else begin
            r_lock_ack <= (r_state == VBLANK) && gl_lock_req;
        end
    end

    // Renderer first, game logic only when the renderer is idle.
    assign w_gl_sel  = ~ren_req & gl_req;
    assign gl_gnt    = ~rst & w_gl_sel;
    assign mem_en    = ~rst & (ren_req | gl_req);
    assign mem_we    = w_gl_sel & gl_we;
    assign mem_addr  = ren_req ? ren_addr : gl_addr;
    assign mem_wdata = gl_wdata;

    // Read-return tagging: the RAM answers one cycle after the access.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ren_valid <= 1'b0;
            r_gl_rvalid <= 1'b0;
        end else begin
            r_ren_valid <= ren_req;
            r_gl_rvalid <= gl_gnt & ~gl_we;
        end
    end

    assign ren_rdata   = mem_rdata;
    assign gl_rdata    = mem_rdata;
    assign ren_valid   = r_ren_valid;
    assign gl_rvalid   = r_gl_rvalid;
    assign gl_lock_ack = r_lock_ack;
    assign frame_tick  = r_frame_tick;
    assign frame_count = r_frame_count;

`ifdef VRAM_ARB_STATS_EN
    logic [c_stall_w-1:0] r_stall_cnt;

    // Count cycles where game logic waited on the renderer; cleared once per frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (r_frame_tick) begin
            r_stall_cnt <= '0;
        end else if (gl_req && !gl_gnt && (r_stall_cnt != {c_stall_w{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign gl_stall_count = r_stall_cnt;
`else
    assign gl_stall_count = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_vram_arbiter.sv
// ============================================================================
//  Module      : tb_vram_arbiter
//  Description : Self-checking bench for vram_arbiter with a RAM model and a
//                behavioural reference of the frame phase, lock and reads.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vram_arbiter;

    localparam int AW = 9;
    localparam int DW = 4;
    localparam int NW = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          vsync, active_area;
    logic          ren_req;
    logic [AW-1:0] ren_addr;
    logic [DW-1:0] ren_rdata;
    logic          ren_valid;
    logic          gl_req, gl_we;
    logic [AW-1:0] gl_addr;
    logic [DW-1:0] gl_wdata;
    logic          gl_gnt;
    logic [DW-1:0] gl_rdata;
    logic          gl_rvalid;
    logic          gl_lock_req, gl_lock_ack;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          frame_tick;
    logic [7:0]    frame_count;
    logic [15:0]   gl_stall_count;

    int total = 0;
    int bad   = 0;

    vram_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk            (clk),
        .rst            (rst),
        .vsync          (vsync),
        .active_area    (active_area),
        .ren_req        (ren_req),
        .ren_addr       (ren_addr),
        .ren_rdata      (ren_rdata),
        .ren_valid      (ren_valid),
        .gl_req         (gl_req),
        .gl_we          (gl_we),
        .gl_addr        (gl_addr),
        .gl_wdata       (gl_wdata),
        .gl_gnt         (gl_gnt),
        .gl_rdata       (gl_rdata),
        .gl_rvalid      (gl_rvalid),
        .gl_lock_req    (gl_lock_req),
        .gl_lock_ack    (gl_lock_ack),
        .mem_en         (mem_en),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .frame_tick     (frame_tick),
        .frame_count    (frame_count),
        .gl_stall_count (gl_stall_count)
    );

    always #5 clk = ~clk;

    // Synchronous-read RAM driven by the DUT's memory port.
    logic [DW-1:0] ram [NW];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    // Reference model: what the arbiter should show after each clock edge.
    logic [DW-1:0] shadow [NW];
    bit            m_vblank;
    bit            m_vs_hist [2];
    bit            m_aa_hist [2];
    bit            e_ren_valid, e_gl_rvalid, e_ack, e_tick;
    logic [DW-1:0] e_ren_data, e_gl_data;
    int            e_count;
    int            e_stall;

    always @(posedge clk) begin
        bit vr, ar, tick_now;
        if (rst) begin
            m_vblank    = 1'b1;
            m_vs_hist   = '{0, 0};
            m_aa_hist   = '{0, 0};
            e_ren_valid = 0;
            e_gl_rvalid = 0;
            e_ack       = 0;
            e_tick      = 0;
            e_count     = 0;
            e_stall     = 0;
        end else begin
            // A rise is seen once the sampled value is high and the sample before it was low.
            vr       = m_vs_hist[0] && !m_vs_hist[1];
            ar       = m_aa_hist[0] && !m_aa_hist[1];
            tick_now = !m_vblank && vr;
            e_ack    = m_vblank && gl_lock_req;
            if (e_tick)                                   e_stall = 0;
            else if (gl_req && ren_req && e_stall < 65535) e_stall = e_stall + 1;
            e_tick = tick_now;
            if (tick_now) e_count = (e_count + 1) % 256;
            if (vr)       m_vblank = 1'b1;
            else if (ar)  m_vblank = 1'b0;
            m_vs_hist[1] = m_vs_hist[0];
            m_vs_hist[0] = vsync;
            m_aa_hist[1] = m_aa_hist[0];
            m_aa_hist[0] = active_area;
            e_ren_valid = ren_req;
            e_gl_rvalid = 0;
            if (ren_req) begin
                e_ren_data = shadow[ren_addr];
            end else if (gl_req) begin
                if (gl_we) shadow[gl_addr] = gl_wdata;
                else begin
                    e_gl_rvalid = 1;
                    e_gl_data   = shadow[gl_addr];
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check combinational arbitration, then the registered results.
    task automatic cyc();
        bit any;
        #1;
        any = !rst && (ren_req || gl_req);
        chk("gl_gnt", 32'(gl_gnt), 32'(!rst && !ren_req && gl_req));
        chk("mem_en", 32'(mem_en), 32'(any));
        if (any) begin
            chk("mem_addr", 32'(mem_addr), 32'(ren_req ? ren_addr : gl_addr));
            chk("mem_we", 32'(mem_we), 32'(!ren_req && gl_we));
        end
        @(posedge clk);
        #1;
        chk("ren_valid", 32'(ren_valid), 32'(e_ren_valid));
        if (e_ren_valid) chk("ren_rdata", 32'(ren_rdata), 32'(e_ren_data));
        chk("gl_rvalid", 32'(gl_rvalid), 32'(e_gl_rvalid));
        if (e_gl_rvalid) chk("gl_rdata", 32'(gl_rdata), 32'(e_gl_data));
        chk("valid_excl", 32'(ren_valid & gl_rvalid), 32'd0);
        chk("lock_ack", 32'(gl_lock_ack), 32'(e_ack));
        chk("frame_tick", 32'(frame_tick), 32'(e_tick));
        chk("frame_count", 32'(frame_count), 32'(e_count));
`ifdef VRAM_ARB_STATS_EN
        chk("stall_count", 32'(gl_stall_count), 32'(e_stall));
`else
        chk("stall_count", 32'(gl_stall_count), 32'd0);
`endif
        @(negedge clk);
    endtask

    task automatic frame();
        active_area = 1; repeat (3) cyc();
        active_area = 0; cyc();
        vsync = 1;       repeat (2) cyc();
        vsync = 0;       repeat (2) cyc();
    endtask

    task automatic idle();
        vsync = 0; active_area = 0; ren_req = 0; ren_addr = '0;
        gl_req = 0; gl_we = 0; gl_addr = '0; gl_wdata = '0; gl_lock_req = 0;
    endtask

    initial begin
        for (int i = 0; i < NW; i++) begin
            ram[i]    = DW'(i);
            shadow[i] = DW'(i);
        end
        idle();
        rst = 1;
        @(negedge clk);

        // Reset with idle inputs.
        repeat (3) cyc();
        rst = 0;
        repeat (2) cyc();

        // Renderer streams addresses 0..7 while game logic is held off.
        gl_req = 1; gl_addr = 9'd100;
        for (int a = 0; a < 8; a++) begin
            ren_req = 1; ren_addr = AW'(a);
            cyc();
        end
        ren_req = 0; gl_req = 0;
        cyc();

        // Game-logic write then read-back of address 5.
        gl_req = 1; gl_we = 1; gl_addr = 9'd5; gl_wdata = 4'hA;
        cyc();
        gl_we = 0;
        cyc();
        gl_req = 0;
        cyc();
        chk("gl_readback", 32'(ram[5]), 32'hA);

        // Three frames from reset.
        repeat (3) frame();
        chk("three_frames", 32'(frame_count), 32'd3);

        // Lock requested during the visible region.
        active_area = 1; repeat (2) cyc();
        gl_lock_req = 1; repeat (3) cyc();
        active_area = 0; vsync = 1; repeat (4) cyc();
        vsync = 0; active_area = 1; repeat (4) cyc();
        gl_lock_req = 0; active_area = 0; repeat (2) cyc();

        // Simultaneous rises: vsync wins.
        active_area = 1; vsync = 1; repeat (3) cyc();
        active_area = 0; vsync = 0; repeat (2) cyc();

        // Stall counting: collisions after a frame tick, cleared by the next one.
        frame();
        ren_req = 1; gl_req = 1; gl_addr = 9'd7;
        repeat (10) cyc();
        ren_req = 0; gl_req = 0;
        cyc();
`ifdef VRAM_ARB_STATS_EN
        chk("stall_ten", 32'(gl_stall_count), 32'd10);
`endif
        frame();

        // Frame counter wrap: bring the count to 256 modulo 256.
        while (frame_count != 8'd0) frame();
        chk("count_wrap", 32'(frame_count), 32'd0);

        // Randomised traffic, phase changes, locks and occasional resets.
        for (int n = 0; n < 1500; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 7) == 0) vsync = ~vsync;
            if ($urandom_range(0, 5) == 0) active_area = ~active_area;
            if ($urandom_range(0, 4) == 0) gl_lock_req = ~gl_lock_req;
            ren_req  = $urandom_range(0, 1) == 1;
            ren_addr = AW'($urandom_range(0, 15));
            gl_req   = $urandom_range(0, 1) == 1;
            gl_we    = $urandom_range(0, 1) == 1;
            gl_addr  = AW'($urandom_range(0, 15));
            gl_wdata = DW'($urandom);
            cyc();
        end
        rst = 0;
        idle();
        repeat (3) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Guard against a stuck simulation.
    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
